// File: rtl/otter_hazard_pkg.sv
// Shared types and helpers for the EX-stage forwarding / load-use hazard controller.
package otter_hazard_pkg;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       is_load;
    logic [4:0] rd;
  } track_entry_t;

  localparam int SEL_REGFILE = 0;

  function automatic int sel_width(input int fwd_depth);
    return $clog2(fwd_depth + 1);
  endfunction

endpackage

// File: rtl/fwd_track_pipe.sv
// Shift register of in-flight instruction records, EX (entry 0) through the last
// forwarding stage; a bubble enters entry 0 when the ID instruction is not issued.
module fwd_track_pipe
  import otter_hazard_pkg::*;
#(
  parameter int FWD_DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       hold_i,
  input  logic                       load_en_i,
  input  track_entry_t               id_entry_i,
  output track_entry_t [FWD_DEPTH:0] entries_o
);

  track_entry_t [FWD_DEPTH:0] entries_q;
  track_entry_t [FWD_DEPTH:0] entries_d;

  // Next pipe contents: freeze on hold, otherwise age every record by one stage.
  always_comb begin
    entries_d = entries_q;
    if (hold_i) begin
      entries_d = entries_q;
    end else begin
      for (int k = FWD_DEPTH; k > 0; k--) begin
        entries_d[k] = entries_q[k-1];
      end
      if (load_en_i) begin
        entries_d[0] = id_entry_i;
      end else begin
        entries_d[0] = '0;
      end
    end
  end

  // Pipe state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entries_q <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

  assign entries_o = entries_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding select and load-use stall generation for the ID->EX boundary.
// Optional stall counter output STALL_CNT is built when HAZARD_PERF_CNT_EN is defined.
module fwd_hazard_ctrl
  import otter_hazard_pkg::*;
#(
  parameter int  NUM_SRC          = 2,
  parameter int  FWD_DEPTH        = 2,
  parameter int  LOAD_READY_STAGE = 2,
  localparam int SW               = sel_width(FWD_DEPTH)
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         HOLD,
  input  logic                         FLUSH,
  input  logic                         ID_VALID,
  input  logic [4:0]                   ID_RD,
  input  logic                         ID_REGWRITE,
  input  logic                         ID_IS_LOAD,
  input  logic [NUM_SRC-1:0][4:0]      ID_RS,
  input  logic [NUM_SRC-1:0]           ID_RS_USED,
  output logic                         STALL,
  output logic [NUM_SRC-1:0][SW-1:0]   SEL
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                  STALL_CNT
`endif
);

  track_entry_t [FWD_DEPTH:0]      entries_s;
  track_entry_t                    id_entry_s;
  logic [NUM_SRC-1:0][FWD_DEPTH:0] rel_s;
  logic [NUM_SRC-1:0]              hit_s;
  logic [NUM_SRC-1:0][SW-1:0]      low_idx_s;
  logic [NUM_SRC-1:0]              early_load_s;
  logic [NUM_SRC-1:0][SW-1:0]      fwd_sel_s;
  logic [NUM_SRC-1:0][SW-1:0]      sel_d;
  logic [NUM_SRC-1:0][SW-1:0]      sel_q;
  logic                            stall_s;
  logic                            load_en_s;

  // Pack the ID instruction into a tracking record.
  always_comb begin
    id_entry_s          = '0;
    id_entry_s.valid    = ID_VALID;
    id_entry_s.regwrite = ID_REGWRITE;
    id_entry_s.is_load  = ID_IS_LOAD;
    id_entry_s.rd       = ID_RD;
  end

  // A bubble enters EX on flush or load-use stall.
  assign load_en_s = !FLUSH && !stall_s;

  fwd_track_pipe #(
    .FWD_DEPTH (FWD_DEPTH)
  ) u_track_pipe (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .hold_i     (HOLD),
    .load_en_i  (load_en_s),
    .id_entry_i (id_entry_s),
    .entries_o  (entries_s)
  );

  // Register-match comparators; x0 and unread sources never match.
  always_comb begin
    rel_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k <= FWD_DEPTH; k++) begin
        rel_s[i][k] = ID_VALID && ID_RS_USED[i] && (ID_RS[i] != 5'd0) &&
                      entries_s[k].valid && entries_s[k].regwrite &&
                      (entries_s[k].rd == ID_RS[i]);
      end
    end
  end

  // Youngest-match priority per source; scanning oldest-first lets the youngest win.
  always_comb begin
    hit_s        = '0;
    low_idx_s    = '0;
    early_load_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = FWD_DEPTH; k >= 0; k--) begin
        if (rel_s[i][k]) begin
          hit_s[i]        = 1'b1;
          low_idx_s[i]    = SW'(k);
          early_load_s[i] = entries_s[k].is_load && ((k + 1) < LOAD_READY_STAGE);
        end else begin
          hit_s[i]        = hit_s[i];
        end
      end
    end
  end

  // Forward select for the ID instruction and the combined load-use stall.
  always_comb begin
    fwd_sel_s = '0;
    stall_s   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (hit_s[i] && (int'(low_idx_s[i]) < FWD_DEPTH)) begin
        fwd_sel_s[i] = low_idx_s[i] + SW'(1);
      end else begin
        fwd_sel_s[i] = SW'(SEL_REGFILE);
      end
      stall_s = stall_s | (hit_s[i] & early_load_s[i]);
    end
  end

  // Select follows the instruction into EX; a bubble always reads the register file.
  always_comb begin
    if (HOLD) begin
      sel_d = sel_q;
    end else if (load_en_s) begin
      sel_d = fwd_sel_s;
    end else begin
      sel_d = '0;
    end
  end

  // Select register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign STALL = stall_s;
  assign SEL   = sel_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Saturating count of edges on which a stall actually took effect.
  always_comb begin
    if (stall_s && !HOLD && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed scenarios then random traffic
// against an instruction-age reference model; a second instance covers a deeper pipe.
module tb_fwd_hazard_ctrl;

  localparam int DA = 2;
  localparam int LA = 2;

  typedef struct {
    bit v;
    bit rw;
    bit ld;
    int rd;
  } instr_t;

  logic            clk;
  logic            rst_n;
  logic            hold;
  logic            flush;
  logic            id_valid;
  logic [4:0]      id_rd;
  logic            id_rw;
  logic            id_ld;
  logic [1:0][4:0] id_rs;
  logic [1:0]      id_used;
  logic            stall_a;
  logic [1:0][1:0] sel_a;
  logic            stall_b;
  logic [1:0][1:0] sel_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]     cnt_a;
  logic [31:0]     cnt_b;
`endif

  instr_t          pipe_m [DA+1];
  logic [1:0][1:0] exp_sel;
  logic [31:0]     exp_cnt;
  logic            st_smp;
  logic            sb_smp;
  int              errors;
  int              checks;

  fwd_hazard_ctrl u_dut_a (
    .CLK         (clk),
    .RST_N       (rst_n),
    .HOLD        (hold),
    .FLUSH       (flush),
    .ID_VALID    (id_valid),
    .ID_RD       (id_rd),
    .ID_REGWRITE (id_rw),
    .ID_IS_LOAD  (id_ld),
    .ID_RS       (id_rs),
    .ID_RS_USED  (id_used),
    .STALL       (stall_a),
    .SEL         (sel_a)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .STALL_CNT   (cnt_a)
`endif
  );

  fwd_hazard_ctrl #(
    .FWD_DEPTH        (3),
    .LOAD_READY_STAGE (3)
  ) u_dut_b (
    .CLK         (clk),
    .RST_N       (rst_n),
    .HOLD        (hold),
    .FLUSH       (flush),
    .ID_VALID    (id_valid),
    .ID_RD       (id_rd),
    .ID_REGWRITE (id_rw),
    .ID_IS_LOAD  (id_ld),
    .ID_RS       (id_rs),
    .ID_RS_USED  (id_used),
    .STALL       (stall_b),
    .SEL         (sel_b)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .STALL_CNT   (cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k <= DA; k++) pipe_m[k] = '{default: 0};
    exp_sel = '0;
    exp_cnt = 32'd0;
  endtask

  // Reference: for each read source find the youngest in-flight writer of that register.
  task automatic model_eval(output logic st, output logic [1:0][1:0] nsel);
    st   = 1'b0;
    nsel = '0;
    for (int i = 0; i < 2; i++) begin
      int y;
      y = -1;
      if (id_valid && id_used[i] && id_rs[i] != 5'd0) begin
        for (int k = 0; k <= DA; k++) begin
          if (y < 0 && pipe_m[k].v && pipe_m[k].rw && pipe_m[k].rd == int'(id_rs[i])) y = k;
        end
      end
      if (y >= 0) begin
        if (pipe_m[y].ld && (y + 1) < LA) st = 1'b1;
        if (y < DA) nsel[i] = 2'(y + 1);
      end
    end
  endtask

  task automatic cyc();
    logic            st;
    logic [1:0][1:0] nsel;
    @(negedge clk);
    model_eval(st, nsel);
    chk("stall", 32'(stall_a), 32'(st));
    st_smp = stall_a;
    sb_smp = stall_b;
    @(posedge clk);
    if (!hold) begin
      if (st && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
      for (int k = DA; k > 0; k--) pipe_m[k] = pipe_m[k-1];
      if (!flush && !st) begin
        pipe_m[0] = '{id_valid, id_rw, id_ld, int'(id_rd)};
        exp_sel   = nsel;
      end else begin
        pipe_m[0] = '{default: 0};
        exp_sel   = '0;
      end
    end
    #1;
    chk("sel", 32'(sel_a), 32'(exp_sel));
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt", cnt_a, exp_cnt);
`endif
  endtask

  task automatic set_id(input logic v, input logic [4:0] rd, input logic rw, input logic ld,
                        input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used);
    id_valid = v;   id_rd = rd;   id_rw = rw;   id_ld = ld;
    id_rs[0] = rs0; id_rs[1] = rs1; id_used = used;
    hold = 1'b0;    flush = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    clear_model();
    chk("rst_async_sel", 32'(sel_a), 32'd0);
    chk("rst_async_stall", 32'(stall_a), 32'd0);
    chk("rst_async_sel_b", 32'(sel_b), 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    st_smp = 1'b0;
    sb_smp = 1'b0;
    rst_n  = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
    clear_model();
    #3;
    chk("reset_sel", 32'(sel_a), 32'd0);
    chk("reset_stall", 32'(stall_a), 32'd0);
    chk("reset_sel_b", 32'(sel_b), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // add x5 ; sub x6,x5,x5
    set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00); cyc();
    set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd5, 2'b11); cyc();
    chk("b2b_sel", 32'(sel_a), 32'h5);
    chk("b2b_stall", 32'(st_smp), 32'd0);

    // writer x7, unrelated, reader x7 ; then two writers of x7, reader
    set_id(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00); cyc();
    set_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd1, 5'd2, 2'b00); cyc();
    set_id(1'b1, 5'd9, 1'b1, 1'b0, 5'd7, 5'd0, 2'b01); cyc();
    chk("mem_fwd_sel", 32'(sel_a), 32'h2);
    set_id(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00); cyc();
    cyc();
    set_id(1'b1, 5'd10, 1'b1, 1'b0, 5'd0, 5'd7, 2'b10); cyc();
    chk("youngest_sel", 32'(sel_a), 32'h4);

    // lw x9 then reader of x9 on both pipe configurations
    do_reset();
    set_id(1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); cyc();
    set_id(1'b1, 5'd11, 1'b1, 1'b0, 5'd9, 5'd0, 2'b01); cyc();
    chk("lu_stall1", 32'(st_smp), 32'd1);
    chk("lu_bubble_sel", 32'(sel_a), 32'd0);
    chk("lu3_stall1", 32'(sb_smp), 32'd1);
    chk("lu3_bubble1", 32'(sel_b), 32'd0);
    cyc();
    chk("lu_stall2", 32'(st_smp), 32'd0);
    chk("lu_wb_sel", 32'(sel_a), 32'h2);
    chk("lu3_stall2", 32'(sb_smp), 32'd1);
    chk("lu3_bubble2", 32'(sel_b), 32'd0);
    cyc();
    chk("lu3_stall3", 32'(sb_smp), 32'd0);
    chk("lu3_sel", 32'(sel_b), 32'h3);

    // x0 and unread sources never forward or stall
    set_id(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); cyc();
    set_id(1'b1, 5'd12, 1'b1, 1'b0, 5'd0, 5'd3, 2'b01); cyc();
    chk("x0_stall", 32'(st_smp), 32'd0);
    chk("x0_sel", 32'(sel_a), 32'd0);
    set_id(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); cyc();
    set_id(1'b1, 5'd13, 1'b1, 1'b0, 5'd0, 5'd3, 2'b01); cyc();
    chk("unused_stall", 32'(st_smp), 32'd0);
    chk("unused_sel", 32'(sel_a), 32'd0);
    set_id(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); cyc();
    set_id(1'b0, 5'd13, 1'b1, 1'b0, 5'd3, 5'd3, 2'b11); cyc();
    chk("novalid_stall", 32'(st_smp), 32'd0);

    // HOLD with FLUSH pulsed: state frozen, forwarding resumes afterwards
    set_id(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00); cyc();
    set_id(1'b1, 5'd7, 1'b1, 1'b0, 5'd7, 5'd0, 2'b01); cyc();
    set_id(1'b1, 5'd14, 1'b1, 1'b0, 5'd0, 5'd7, 2'b10);
    hold = 1'b1; flush = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cyc();
      chk("hold_sel", 32'(sel_a), 32'h1);
    end
    hold = 1'b0; flush = 1'b0; cyc();
    chk("post_hold_sel", 32'(sel_a), 32'h4);
    set_id(1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); cyc();
    set_id(1'b1, 5'd15, 1'b1, 1'b0, 5'd9, 5'd0, 2'b01);
    hold = 1'b1; flush = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cyc();
      chk("hold_stall", 32'(st_smp), 32'd1);
    end
    hold = 1'b0; flush = 1'b0; cyc();
    chk("post_hold_lu_stall", 32'(st_smp), 32'd1);
    chk("post_hold_lu_sel", 32'(sel_a), 32'd0);
    cyc();
    chk("post_hold_lu_fwd", 32'(sel_a), 32'h2);
    set_id(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00); cyc();
    set_id(1'b1, 5'd16, 1'b1, 1'b0, 5'd7, 5'd0, 2'b01);
    flush = 1'b1; cyc();
    chk("flush_sel", 32'(sel_a), 32'd0);
    flush = 1'b0; cyc();
    chk("flush_keeps_older", 32'(sel_a), 32'h2);

    // Reset mid-stream: no stale forwarding afterwards
    set_id(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00); cyc();
    set_id(1'b1, 5'd16, 1'b1, 1'b0, 5'd7, 5'd0, 2'b01); cyc();
    chk("pre_rst_sel", 32'(sel_a), 32'h1);
    do_reset();
    set_id(1'b1, 5'd17, 1'b1, 1'b0, 5'd7, 5'd7, 2'b11); cyc();
    chk("post_rst_sel", 32'(sel_a), 32'd0);
    chk("post_rst_stall", 32'(st_smp), 32'd0);

    // Five single-cycle load-use stalls
    do_reset();
    for (int n = 0; n < 5; n++) begin
      set_id(1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); cyc();
      set_id(1'b1, 5'd18, 1'b1, 1'b0, 5'd0, 5'd9, 2'b10); cyc();
    end
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt_5", cnt_a, 32'd5);
`endif

    // Random traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      id_valid = ($urandom_range(0, 9) != 0);
      id_rd    = 5'($urandom_range(0, 3));
      id_rw    = 1'($urandom_range(0, 1));
      id_ld    = ($urandom_range(0, 2) == 0);
      id_rs[0] = 5'($urandom_range(0, 3));
      id_rs[1] = 5'($urandom_range(0, 3));
      id_used  = 2'($urandom_range(0, 3));
      hold     = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
